adder4_seq_ctrl: RTL and testbench



---
 rtl/adder4_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_adder4_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder4_seq_ctrl.sv
// adder4_seq_ctrl: WIDTH-bit add (optionally subtract) computed one nibble per
// cycle, LSB nibble first, on a single shared 4-bit ripple adder (adder4).
// Operands and results use valid/ready handshakes; carry is chained through
// a register between nibbles.
// Optional feature macro: ADD4_SEQ_SUB_EN adds the in_sub port (A - B).

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    // 4-bit ripple carry chain
    always_comb begin
        logic c;
        c   = cin;
        sum = 4'b0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end
endmodule

module adder4_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADD4_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef ADD4_SEQ_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [WIDTH-1:0]   b_eff;
    logic [3:0]         a_nib, b_nib, add_sum;
    logic               add_cout;
    logic               last_nib;

    // Effective B operand: inverted for subtraction when enabled
`ifdef ADD4_SEQ_SUB_EN
    assign b_eff = sub_q ? ~b_q : b_q;
`else
    assign b_eff = b_q;
`endif

    assign a_nib    = 4'(a_q >> {idx_q, 2'b00});
    assign b_nib    = 4'(b_eff >> {idx_q, 2'b00});
    assign last_nib = (idx_q == IDX_W'(NIB - 1));

    adder4 u_adder4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef ADD4_SEQ_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    idx_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
`ifdef ADD4_SEQ_SUB_EN
                    sub_d      = in_sub;
                    carry_d    = in_sub ? 1'b1 : in_cin;
`else
                    carry_d    = in_cin;
`endif
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (last_nib) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    ovf_d       = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                                  (add_sum[3] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ADD4_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ADD4_SEQ_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Self-checking bench for adder4_seq_ctrl (WIDTH=16) against an integer
// arithmetic reference model. Subtraction scenarios run when ADD4_SEQ_SUB_EN
// is defined.

module tb_adder4_seq_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder4_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADD4_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] sum, output logic cout,
                                  output logic ovf);
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            cout = (ua >= ub);
        end else begin
            ures = ua + ub + longint'(cin);
            sres = sa + sb + longint'(cin);
            cout = (ures >= 65536);
        end
        sum = W'(ures);
        ovf = (sres > 32767) || (sres < -32768);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency check, optional back-pressure, result check, handshake
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int hold,
                          input string name);
        logic [W-1:0] e_sum;
        logic         e_cout, e_ovf;
        int           cnt;
        model(a, b, cin, sub, e_sum, e_cout, e_ovf);
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready_wait got=%b want=1", name, in_ready);
        end
        out_ready = 1'b0;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_cin    = 1'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== NIB) begin
            failures++;
            $display("FAIL %s latency got=%0d want=%0d", name, cnt, NIB);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e_sum) begin
                failures++;
                $display("FAIL %s hold valid=%b ready=%b sum=%h want 1 0 %h",
                         name, out_valid, in_ready, out_sum, e_sum);
            end
        end
        checks++;
        if (out_sum !== e_sum || out_cout !== e_cout || out_ovf !== e_ovf) begin
            failures++;
            $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, out_sum, out_cout, out_ovf, e_sum, e_cout, e_ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s post_handshake in_ready=%b out_valid=%b want 1 0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset got ready=%b valid=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, "add_1234_0fff");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_ffff_0001");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, "add_cin_only");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_pos_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, "add_neg_ovf");
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1, "add_cin_ovf");
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] e_sum;
        logic         e_cout, e_ovf;
        int           cnt;
        model(16'hA5A5, 16'h1357, 1'b1, 1'b0, e_sum, e_cout, e_ovf);
        out_ready = 1'b0;
        in_a = 16'hA5A5; in_b = 16'h1357; in_cin = 1'b1; in_sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e_sum ||
                out_cout !== e_cout || out_ovf !== e_ovf) begin
                failures++;
                $display("FAIL back_pressure cyc=%0d valid=%b ready=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                         i, out_valid, in_ready, out_sum, out_cout, out_ovf, e_sum, e_cout, e_ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL back_pressure_release cyc=%0d ready=%b valid=%b want 1 0",
                         i, in_ready, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        in_a = 16'h4321; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun got ready=%b valid=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_edge_accept in_ready=%b want 1", in_ready);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "after_reset_00ff");
    endtask

    task automatic test_sub();
`ifdef ADD4_SEQ_SUB_EN
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, "sub_7_5");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "sub_5_7");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_8000_1");
        run_op(16'h0000, 16'h8000, 1'b1, 1'b1, 0, "sub_0_8000");
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic sub;
`ifdef ADD4_SEQ_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), sub,
                   int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_midrun();
        test_sub();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
